// File: rtl/board_scan.sv
// board_scan: sweeps all board cells through the mine/reveal/flag memory read
// ports, accumulates game statistics and publishes a coherent snapshot once
// per completed sweep.
module board_scan #(
    parameter int unsigned CELLS  = 256,
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned CNT_W  = 9
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              scan_en,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              rd_en,
    input  logic              mine_q,
    input  logic              revealed_q,
    input  logic              flag_q,
    output logic [CNT_W-1:0]  reveal_safe_count,
    output logic [CNT_W-1:0]  flag_count,
    output logic              mine_revealed,
    output logic              busy,
    output logic              scan_done
);

    // The sweep end is the natural address wrap, so the cell count must match.
    if (CELLS != (1 << ADDR_W)) begin : g_bad_cells
        $error("board_scan: CELLS must equal 2**ADDR_W");
    end

    typedef enum logic [1:0] {
        StIdle,
        StRead,
        StDrain,
        StPublish
    } state_e;

    state_e             state;
    logic               valid_q;
    logic [CNT_W-1:0]   safe_acc;
    logic [CNT_W-1:0]   flag_acc;
    logic               mine_acc;
    logic [CNT_W-1:0]   safe_d;
    logic [CNT_W-1:0]   flag_d;
    logic               mine_d;
    logic [ADDR_W:0]    addr_inc;

    // Carry out of the address increment marks the last cell of the sweep.
    assign addr_inc = {1'b0, rd_addr} + {{ADDR_W{1'b0}}, 1'b1};

    // Next accumulator values: fold in memory data returned for last cycle's read.
    always_comb begin
        safe_d = safe_acc;
        flag_d = flag_acc;
        mine_d = mine_acc;
        if (valid_q) begin
            safe_d = safe_acc + CNT_W'(revealed_q & ~mine_q);
            flag_d = flag_acc + CNT_W'(flag_q & ~revealed_q);
            mine_d = mine_acc | (revealed_q & mine_q);
        end
    end

    // Sweep FSM with registered read port, accumulators and published snapshot.
    always_ff @(posedge clk) begin
        if (rst) begin
            state             <= StIdle;
            rd_addr           <= '0;
            rd_en             <= 1'b0;
            valid_q           <= 1'b0;
            busy              <= 1'b0;
            scan_done         <= 1'b0;
            safe_acc          <= '0;
            flag_acc          <= '0;
            mine_acc          <= 1'b0;
            reveal_safe_count <= '0;
            flag_count        <= '0;
            mine_revealed     <= 1'b0;
        end else begin
            valid_q   <= rd_en;
            scan_done <= 1'b0;
            safe_acc  <= safe_d;
            flag_acc  <= flag_d;
            mine_acc  <= mine_d;
            unique case (state)
                StIdle: begin
                    if (start || scan_en) begin
                        state    <= StRead;
                        rd_en    <= 1'b1;
                        rd_addr  <= '0;
                        busy     <= 1'b1;
                        safe_acc <= '0;
                        flag_acc <= '0;
                        mine_acc <= 1'b0;
                    end
                end
                StRead: begin
                    rd_addr <= addr_inc[ADDR_W-1:0];
                    if (addr_inc[ADDR_W]) begin
                        state <= StDrain;
                        rd_en <= 1'b0;
                    end
                end
                StDrain: begin
                    // Publish includes the final cell's data arriving this cycle.
                    reveal_safe_count <= safe_d;
                    flag_count        <= flag_d;
                    mine_revealed     <= mine_d;
                    scan_done         <= 1'b1;
                    state             <= StPublish;
                end
                StPublish: begin
                    if (scan_en) begin
                        state    <= StRead;
                        rd_en    <= 1'b1;
                        rd_addr  <= '0;
                        safe_acc <= '0;
                        flag_acc <= '0;
                        mine_acc <= 1'b0;
                    end else begin
                        state <= StIdle;
                        busy  <= 1'b0;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: doc/board_scan.md
# board_scan

Read-side companion to the play-state logic that writes the flag and reveal memories. The block sweeps all 256 board cells through the read ports of the mine, reveal and flag memories and accumulates board statistics. It publishes a coherent snapshot once per sweep:
- `reveal_safe_count`, which feeds win detection;
- `flag_count`;
- `mine_revealed`, a loss flag.

It sits between the board memories and the game/play state logic. It owns the memory read address for the whole sweep.

## Interface
Parameters:
- `CELLS`, 256, number of board cells; fixed at 256 for this board.
- `ADDR_W`, 8, cell address width.
- `CNT_W`, 9, counter width; must hold values 0..256.

Ports:
- `clk`  in  1  system clock; single clock domain.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  one-shot sweep request; sampled only in IDLE.
- `scan_en`  in  1  continuous mode; sweeps back-to-back while high.
- `rd_addr`  out  8  cell address driven to all three memories.
- `rd_en`  out  1  read strobe; high when `rd_addr` is valid.
- `mine_q`  in  1  mine_map data; valid 1 cycle after `rd_addr`.
- `revealed_q`  in  1  revealed_map data; same 1-cycle latency.
- `flag_q`  in  1  flag_map data; same 1-cycle latency.
- `reveal_safe_count`  out  9  published count of revealed non-mine cells.
- `flag_count`  out  9  published count of flagged, unrevealed cells.
- `mine_revealed`  out  1  published: at least one cell is both revealed and a mine.
- `busy`  out  1  high from the first READ cycle through PUBLISH.
- `scan_done`  out  1  one-cycle pulse in the cycle the published outputs update.

## Operation
States:
- **IDLE.**
  - Go to READ if `start` or `scan_en` is high.
  - Clear the accumulators on that transition.
  - `start` is ignored in every other state; it is not queued.
- **READ.**
  - Drive `rd_en=1` and `rd_addr=k` for k = 0..255, one cell per cycle.
  - After k = 255, go to DRAIN.
- **DRAIN.**
  - `rd_en=0`.
  - Capture the data for cell 255.
  - Go to PUBLISH.
- **PUBLISH.**
  - Copy the accumulators to the published outputs.
  - Assert `scan_done`.
  - If `scan_en` is high: clear the accumulators and go to READ.
  - Otherwise go to IDLE.

Accumulation happens in every cycle whose preceding cycle had `rd_en=1`, i.e. a registered copy of `rd_en` acts as the data-valid flag:
- `safe_acc += revealed_q & ~mine_q`
- `flag_acc += flag_q & ~revealed_q`
- `mine_acc |= revealed_q & mine_q`

Width rules:
- All counts are 9-bit unsigned; the maximum is 256, so no overflow is possible.
- The address counter is 8 bits; the 255→0 wrap is the sweep end condition, with no separate compare to 256.

Other rules:
- Published outputs change only in PUBLISH. Consumers see a stable snapshot from the last complete sweep, never a partial count.
- The memory write ports are not touched. Writes that land mid-sweep are reflected in the next sweep.

## Timing
- Reset values:
  - `rd_addr=0`, `rd_en=0`, `busy=0`, `scan_done=0`.
  - `reveal_safe_count=0`, `flag_count=0`, `mine_revealed=0`.
  - State IDLE; accumulators 0.
- Sweep latency:
  - The request seen in IDLE at cycle T puts the machine in READ at T+1 with `rd_addr=0`.
  - Cell 255 is addressed at T+256; DRAIN is at T+257.
  - PUBLISH and `scan_done` occur at T+258.
  - With `scan_en` high, the period is 258 cycles between `scan_done` pulses.
- `busy` is high T+1..T+258 inclusive.
- `rst` asserted mid-sweep: the sweep aborts, all outputs return to reset values, and there is no `scan_done`.
- `start` and `scan_en` both high in IDLE: one sweep starts. Continuation is decided by `scan_en` at PUBLISH.
- `scan_en` dropped mid-sweep: the current sweep completes and publishes, then the machine goes to IDLE.

## Test plan
- All memories zero, pulse `start` → `rd_addr` 0..255 on consecutive cycles; `scan_done` 258 cycles after `start`; outputs 0/0/0.
- Cells 0..9 revealed with no mines; flags on cells 20, 21, 22 (unrevealed) and cell 5 (revealed) → `reveal_safe_count=10`, `flag_count=3`, `mine_revealed=0`.
- Cell 255 revealed and a mine; cell 254 revealed and safe → `mine_revealed=1`, `reveal_safe_count=1`. This proves the DRAIN capture.
- All 256 cells revealed, no mines → `reveal_safe_count=256` with no wrap.
- `scan_en` held high for three sweeps, with cell 0's reveal bit set during sweep 2 after address 0 has passed → count +1 only at the third `scan_done`; `scan_done` pulses 258 cycles apart.
- `rst` pulsed at address 100 → outputs return to 0, state IDLE, and no `scan_done`; a second `start` pulse during `busy` is ignored.
